// File: rtl/color_scan_scheduler.sv
// Measurement scheduler between the CLS381 sensor and the WS2812 display: periodic trigger,
// consecutive-sample colour filter and LED request handshake. Optional: COLOR_SCHED_TIMEOUT_EN.
module color_scan_scheduler #(
   parameter int unsigned PERIOD_CYC  = 5_000_000,
   parameter int unsigned CONFIRM_N   = 3,
   parameter int unsigned TIMEOUT_CYC = 2_500_000
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   output logic       meas_start,
   input  logic       meas_done,
   input  logic       r_valid,
   input  logic       g_valid,
   input  logic       b_valid,
   output logic       led_req,
   output logic [2:0] led_color,
   input  logic       led_ack,
   output logic       busy,
   output logic       sensor_err
);

   localparam int unsigned PW = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_WAIT,
      S_EVAL
   } state_t;

   state_t        state, state_nx;
   logic [PW-1:0] period_cnt;
   logic          tick;
   logic          timeout;
   logic [2:0]    sample;
   logic [2:0]    cand, cand_nx;
   logic [3:0]    conf_cnt, conf_cnt_nx;
   logic          confirm;
   logic          upd;
   logic [2:0]    shown;
   logic [2:0]    pend_color;
   logic          pend_valid;

   assign tick = (period_cnt == PW'(PERIOD_CYC - 1));

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         period_cnt <= '0;
      end else if (tick) begin
         period_cnt <= '0;
      end else begin
         period_cnt <= period_cnt + 1'b1;
      end
   end

`ifdef COLOR_SCHED_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] to_cnt;

   // Counts from the START cycle, so the error shows TIMEOUT_CYC cycles after meas_start.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         to_cnt <= '0;
      end else if (state == S_START || state == S_WAIT) begin
         to_cnt <= to_cnt + 1'b1;
      end else begin
         to_cnt <= '0;
      end
   end

   assign timeout = (state == S_WAIT) && !meas_done && (to_cnt == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sensor_err <= 1'b0;
      end else if (timeout) begin
         sensor_err <= 1'b1;
      end
   end
`else
   assign timeout    = 1'b0;
   assign sensor_err = 1'b0;
`endif

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      meas_start = 1'b0;
      case (state)
         S_IDLE:  if (tick) state_nx = S_START;
         S_START: begin
            meas_start = 1'b1;
            state_nx   = S_WAIT;
         end
         S_WAIT: begin
            if (meas_done) begin
               state_nx = S_EVAL;
            end else if (timeout) begin
               state_nx = S_IDLE;
            end
         end
         S_EVAL:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   assign busy = (state != S_IDLE);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sample <= '0;
      end else if (state == S_WAIT && meas_done) begin
         sample <= {r_valid, g_valid, b_valid};
      end
   end

   // Confirm fires only on the transition into CONFIRM_N, never while saturated.
   always_comb begin
      cand_nx     = cand;
      conf_cnt_nx = conf_cnt;
      confirm     = 1'b0;
      if (state == S_EVAL) begin
         if (sample == cand) begin
            if (conf_cnt < 4'(CONFIRM_N)) begin
               conf_cnt_nx = conf_cnt + 4'd1;
               confirm     = (conf_cnt + 4'd1 == 4'(CONFIRM_N));
            end
         end else begin
            cand_nx     = sample;
            conf_cnt_nx = 4'd1;
            confirm     = (CONFIRM_N == 1);
         end
      end
   end

   assign upd = confirm && (cand_nx != shown);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cand     <= '0;
         conf_cnt <= '0;
      end else begin
         cand     <= cand_nx;
         conf_cnt <= conf_cnt_nx;
      end
   end

   // A pending colour is only ever launched from the idle cycle that follows an ack.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         led_req    <= 1'b0;
         led_color  <= '0;
         shown      <= '0;
         pend_valid <= 1'b0;
         pend_color <= '0;
      end else if (led_req) begin
         if (upd) begin
            pend_valid <= 1'b1;
            pend_color <= cand_nx;
         end
         if (led_ack) begin
            led_req <= 1'b0;
            if (!upd && pend_valid && pend_color == shown) begin
               pend_valid <= 1'b0;
            end
         end
      end else if (upd) begin
         led_req    <= 1'b1;
         led_color  <= cand_nx;
         shown      <= cand_nx;
         pend_valid <= 1'b0;
      end else if (pend_valid) begin
         led_req    <= 1'b1;
         led_color  <= pend_color;
         shown      <= pend_color;
         pend_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_color_scan_scheduler.sv
// Directed bench for color_scan_scheduler (PERIOD_CYC=100, CONFIRM_N=3, TIMEOUT_CYC=40).
// The timeout section runs only when COLOR_SCHED_TIMEOUT_EN is defined.
module tb_color_scan_scheduler;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n;
   logic       meas_start;
   logic       meas_done;
   logic       r_valid, g_valid, b_valid;
   logic       led_req;
   logic [2:0] led_color;
   logic       led_ack;
   logic       busy;
   logic       sensor_err;

   int errors = 0;
   int checks = 0;

   always #5 sys_clk = ~sys_clk;

   color_scan_scheduler #(
      .PERIOD_CYC (100),
      .CONFIRM_N  (3),
      .TIMEOUT_CYC(40)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .meas_start(meas_start),
      .meas_done (meas_done),
      .r_valid   (r_valid),
      .g_valid   (g_valid),
      .b_valid   (b_valid),
      .led_req   (led_req),
      .led_color (led_color),
      .led_ack   (led_ack),
      .busy      (busy),
      .sensor_err(sensor_err)
   );

   task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] req);
      checks++;
      assert (obs === req) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, req);
      end
   endtask

   // Waits (bounded) for meas_start, answers one cycle later, returns in the EVAL cycle.
   task automatic do_meas(input logic [2:0] c);
      int n = 0;
      while (meas_start !== 1'b1 && n < 300) begin
         @(negedge sys_clk);
         n++;
      end
      chk("meas_start_seen", {2'b00, meas_start}, 3'b001);
      @(negedge sys_clk);
      chk("meas_start_width", {2'b00, meas_start}, 3'b000);
      {r_valid, g_valid, b_valid} = c;
      meas_done = 1'b1;
      @(negedge sys_clk);
      meas_done = 1'b0;
      {r_valid, g_valid, b_valid} = 3'b000;
      chk("busy_eval", {2'b00, busy}, 3'b001);
   endtask

   initial begin
      logic       early;
      logic [2:0] seq [5];
      int         n;

      sys_rst_n = 1'b0;
      meas_done = 1'b0;
      {r_valid, g_valid, b_valid} = 3'b000;
      led_ack   = 1'b0;
      repeat (3) @(negedge sys_clk);
      chk("rst_meas_start", {2'b00, meas_start}, 3'b000);
      chk("rst_busy", {2'b00, busy}, 3'b000);
      chk("rst_led_req", {2'b00, led_req}, 3'b000);
      chk("rst_led_color", led_color, 3'b000);
      chk("rst_sensor_err", {2'b00, sensor_err}, 3'b000);

      // First meas_start must appear after exactly 100 clock edges.
      sys_rst_n = 1'b1;
      early = 1'b0;
      for (int i = 1; i <= 99; i++) begin
         @(negedge sys_clk);
         if (meas_start || busy) early = 1'b1;
      end
      chk("no_early_start", {2'b00, early}, 3'b000);
      @(negedge sys_clk);
      chk("start_at_100", {2'b00, meas_start}, 3'b001);
      chk("busy_start", {2'b00, busy}, 3'b001);
      @(negedge sys_clk);
      chk("start_one_wide", {2'b00, meas_start}, 3'b000);
      chk("busy_wait", {2'b00, busy}, 3'b001);
      {r_valid, g_valid, b_valid} = 3'b100;
      meas_done = 1'b1;
      @(negedge sys_clk);
      meas_done = 1'b0;
      {r_valid, g_valid, b_valid} = 3'b000;
      @(negedge sys_clk);
      chk("red1_noreq", {2'b00, led_req}, 3'b000);
      chk("idle_after_eval", {2'b00, busy}, 3'b000);

      do_meas(3'b100);
      @(negedge sys_clk);
      chk("red2_noreq", {2'b00, led_req}, 3'b000);
      do_meas(3'b100);
      chk("red3_latency_low", {2'b00, led_req}, 3'b000);
      @(negedge sys_clk);
      chk("red3_req", {2'b00, led_req}, 3'b001);
      chk("red3_color", led_color, 3'b100);
      led_ack = 1'b1;
      @(negedge sys_clk);
      led_ack = 1'b0;
      chk("ack_drop", {2'b00, led_req}, 3'b000);
      repeat (3) @(negedge sys_clk);
      chk("no_refire", {2'b00, led_req}, 3'b000);

      // Stray ack and stray meas_done while idle are ignored.
      led_ack = 1'b1;
      meas_done = 1'b1;
      {r_valid, g_valid, b_valid} = 3'b010;
      @(negedge sys_clk);
      led_ack = 1'b0;
      meas_done = 1'b0;
      {r_valid, g_valid, b_valid} = 3'b000;
      @(negedge sys_clk);
      chk("stray_ack", {2'b00, led_req}, 3'b000);
      chk("stray_done", {2'b00, busy}, 3'b000);

      do_meas(3'b100);
      @(negedge sys_clk);
      chk("red4_saturated", {2'b00, led_req}, 3'b000);
      repeat (3) @(negedge sys_clk);
      chk("red4_still_idle", {2'b00, led_req}, 3'b000);

      // Interrupted runs never reach CONFIRM_N.
      seq = '{3'b010, 3'b010, 3'b001, 3'b010, 3'b010};
      for (int i = 0; i < 5; i++) begin
         do_meas(seq[i]);
         @(negedge sys_clk);
         chk("interrupted_noreq", {2'b00, led_req}, 3'b000);
      end
      do_meas(3'b010);
      @(negedge sys_clk);
      chk("green_req", {2'b00, led_req}, 3'b001);
      chk("green_color", led_color, 3'b010);

      // Asynchronous reset while a request is outstanding.
      sys_rst_n = 1'b0;
      #1;
      chk("midrst_led_req", {2'b00, led_req}, 3'b000);
      chk("midrst_led_color", led_color, 3'b000);
      chk("midrst_busy", {2'b00, busy}, 3'b000);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;

      for (int i = 0; i < 3; i++) do_meas(3'b100);
      @(negedge sys_clk);
      chk("red_again_req", {2'b00, led_req}, 3'b001);
      chk("red_again_color", led_color, 3'b100);
      for (int i = 0; i < 3; i++) do_meas(3'b010);
      @(negedge sys_clk);
      chk("held_after_green", {2'b00, led_req}, 3'b001);
      chk("color_stable_green", led_color, 3'b100);
      for (int i = 0; i < 3; i++) do_meas(3'b001);
      @(negedge sys_clk);
      chk("held_after_blue", {2'b00, led_req}, 3'b001);
      chk("color_stable_blue", led_color, 3'b100);
      led_ack = 1'b1;
      @(negedge sys_clk);
      led_ack = 1'b0;
      chk("gap_low", {2'b00, led_req}, 3'b000);
      @(negedge sys_clk);
      chk("pending_req", {2'b00, led_req}, 3'b001);
      chk("pending_color", led_color, 3'b001);
      led_ack = 1'b1;
      @(negedge sys_clk);
      led_ack = 1'b0;
      chk("pending_ack_drop", {2'b00, led_req}, 3'b000);
      repeat (3) @(negedge sys_clk);
      chk("no_third_frame", {2'b00, led_req}, 3'b000);

`ifdef COLOR_SCHED_TIMEOUT_EN
      chk("err_clear_before", {2'b00, sensor_err}, 3'b000);
      n = 0;
      while (meas_start !== 1'b1 && n < 300) begin
         @(negedge sys_clk);
         n++;
      end
      chk("to_start_seen", {2'b00, meas_start}, 3'b001);
      repeat (39) @(negedge sys_clk);
      chk("err_not_yet", {2'b00, sensor_err}, 3'b000);
      chk("busy_still_wait", {2'b00, busy}, 3'b001);
      @(negedge sys_clk);
      chk("err_at_40", {2'b00, sensor_err}, 3'b001);
      chk("idle_after_timeout", {2'b00, busy}, 3'b000);
      do_meas(3'b010);
      @(negedge sys_clk);
      chk("err_sticky", {2'b00, sensor_err}, 3'b001);
`else
      n = 0;
      chk("err_tied_low", {2'b00, sensor_err}, 3'b000);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
